// File: rtl/cellrv32_package.sv
// Shared cellrv32 definitions: IO address map constants, helpers and the
// IO gateway state/response types.
package cellrv32_package;

  // processor-internal IO window
  localparam logic [31:0] io_base_c = 32'hFFFFFE00;
  localparam int          io_size_c = 512;

  // IO bus timeout limit in BUSY cycles (at least 2)
  localparam int io_gw_timeout_c = 15;

  // smallest n with 2**n >= num (bit index of an aligned window)
  function automatic int index_size_f(input int num);
    int res;
    res = 0;
    for (int i = 31; i >= 0; i--) begin
      if ((longint'(1) << i) >= longint'(num)) begin
        res = i;
      end
    end
    return res;
  endfunction

  // IO gateway FSM states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } io_gw_state_t;

  // merged wired-OR device response
  typedef struct packed {
    logic [31:0] data;
    logic        ack;
    logic        err;
    logic        multi;
  } io_gw_rsp_t;

endpackage

// File: rtl/cellrv32_io_gateway_if.sv
// Host-side and device-side signals of the IO gateway. The slave modport is
// the gateway's view; the master modport is the view of the CPU plus devices.
interface cellrv32_io_gateway_if #(
  parameter int NUM_DEV = 8
);

  // host bus
  logic [31:0]           addr_i;
  logic                  rden_i;
  logic                  wren_i;
  logic [31:0]           data_i;
  logic [3:0]            ben_i;
  logic [31:0]           data_o;
  logic                  ack_o;
  logic                  err_o;

  // device bus
  logic [31:0]           io_addr_o;
  logic                  io_rden_o;
  logic                  io_wren_o;
  logic [31:0]           io_data_o;
  logic [3:0]            io_ben_o;
  logic [NUM_DEV*32-1:0] dev_data_i;
  logic [NUM_DEV-1:0]    dev_ack_i;
  logic [NUM_DEV-1:0]    dev_err_i;

  modport master (
    output addr_i, rden_i, wren_i, data_i, ben_i,
    output dev_data_i, dev_ack_i, dev_err_i,
    input  data_o, ack_o, err_o,
    input  io_addr_o, io_rden_o, io_wren_o, io_data_o, io_ben_o
  );

  modport slave (
    input  addr_i, rden_i, wren_i, data_i, ben_i,
    input  dev_data_i, dev_ack_i, dev_err_i,
    output data_o, ack_o, err_o,
    output io_addr_o, io_rden_o, io_wren_o, io_data_o, io_ben_o
  );

endinterface

// File: rtl/cellrv32_io_gateway.sv
// Single-outstanding gateway from the CPU data bus into the IO device space.
// Decodes the IO window, issues one-cycle device strobes, merges the wired-OR
// device responses and answers the host with a registered ack/err/data word.
// A missing device response is turned into a bus error after TIMEOUT cycles.
module cellrv32_io_gateway
  import cellrv32_package::*;
#(
  parameter int          TIMEOUT = io_gw_timeout_c,
  parameter int          NUM_DEV = 8,
  parameter logic [31:0] IO_BASE = io_base_c,
  parameter int          IO_SIZE = io_size_c
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cellrv32_io_gateway_if.slave bus
);

  localparam int                 win_lsb_c  = index_size_f(IO_SIZE);
  localparam int                 cnt_w_c    = $clog2(TIMEOUT + 1);
  localparam logic [cnt_w_c-1:0] cnt_max_c  = cnt_w_c'(TIMEOUT);
  localparam logic [cnt_w_c-1:0] cnt_last_c = cnt_w_c'(TIMEOUT - 1);

  io_gw_state_t       state, state_nxt;
  logic [cnt_w_c-1:0] cnt;
  logic               rd_q;
  logic               win_hit;
  logic               accept;
  logic               done_ack;
  logic               done_err;
  io_gw_rsp_t         rsp;

  // OR-reduce all device slices; more than one ack bit is a decode conflict
  function automatic io_gw_rsp_t merge_f(input logic [NUM_DEV*32-1:0] d,
                                         input logic [NUM_DEV-1:0]    a,
                                         input logic [NUM_DEV-1:0]    e);
    io_gw_rsp_t r;
    r = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      r.data = r.data | d[i*32 +: 32];
    end
    r.ack   = |a;
    r.err   = |e;
    r.multi = (a & (a - NUM_DEV'(1))) != '0;
    return r;
  endfunction

  assign rsp     = merge_f(bus.dev_data_i, bus.dev_ack_i, bus.dev_err_i);
  assign win_hit = (bus.addr_i[31:win_lsb_c] == IO_BASE[31:win_lsb_c]);

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // accept in IDLE; in BUSY resolve error, single ack, then timeout
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ack  = 1'b0;
    done_err  = 1'b0;
    case (state)
      IDLE: begin
        if ((bus.rden_i || bus.wren_i) && win_hit) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (rsp.err || rsp.multi) begin
          done_err  = 1'b1;
          state_nxt = IDLE;
        end else if (rsp.ack) begin
          done_ack  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt >= cnt_last_c) begin
          done_err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // saturating BUSY-cycle counter, cleared on every accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == BUSY) && (cnt != cnt_max_c)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // latch the request, pulse strobes and register the host response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.io_addr_o <= '0;
      bus.io_data_o <= '0;
      bus.io_ben_o  <= '0;
      bus.io_rden_o <= 1'b0;
      bus.io_wren_o <= 1'b0;
      bus.data_o    <= '0;
      bus.ack_o     <= 1'b0;
      bus.err_o     <= 1'b0;
      rd_q          <= 1'b0;
    end else begin
      bus.io_rden_o <= 1'b0;
      bus.io_wren_o <= 1'b0;
      bus.ack_o     <= done_ack;
      bus.err_o     <= done_err;
      bus.data_o    <= (done_ack && rd_q) ? rsp.data : 32'h0;
      if (accept) begin
        bus.io_addr_o <= bus.addr_i;
        bus.io_ben_o  <= bus.ben_i;
        bus.io_wren_o <= bus.wren_i;
        bus.io_rden_o <= bus.rden_i & ~bus.wren_i;
        bus.io_data_o <= bus.wren_i ? bus.data_i : 32'h0;
        rd_q          <= ~bus.wren_i;
      end
    end
  end

endmodule

// File: tb/tb_cellrv32_io_gateway.sv
// Scoreboard bench for cellrv32_io_gateway: directed requests push expected
// host responses, a monitor pops and compares whenever ack_o/err_o appears.
// A small behavioural device model sits on the device side.
module tb_cellrv32_io_gateway;

  logic clk_i;
  logic rst_i;

  cellrv32_io_gateway_if #(.NUM_DEV(8)) bus ();

  cellrv32_io_gateway #(
    .TIMEOUT(15),
    .NUM_DEV(8),
    .IO_BASE(32'hFFFFFE00),
    .IO_SIZE(512)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  int          exp_strobes = 0;

  logic [31:0] scratch = 32'h0;
  int          pend_cnt = 0;
  logic [31:0] p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_ben;
  logic        p_wr;

  // free-running clock and cycle counter
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one device response for the captured strobe
  task automatic devRespond();
    if (p_addr[31:5] == 27'h7FFFFFF) begin
      if (p_wr) begin
        bus.dev_err_i[0] = 1'b1;
      end else begin
        bus.dev_ack_i[0] = 1'b1;
        bus.dev_data_i[0*32 +: 32] = (p_addr[4:2] == 3'd0) ? 32'h05F5E100 : (32'h100 + 32'(p_addr[4:2]));
      end
    end else if (p_addr == 32'hFFFFFE00) begin
      bus.dev_ack_i[3] = 1'b1;
      if (p_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (p_ben[b]) scratch[b*8 +: 8] = p_data[b*8 +: 8];
        end
      end else begin
        bus.dev_data_i[3*32 +: 32] = scratch;
      end
    end else if (p_addr == 32'hFFFFFF80) begin
      bus.dev_ack_i[5] = 1'b1;
      bus.dev_ack_i[6] = 1'b1;
      bus.dev_data_i[5*32 +: 32] = 32'h00FF0000;
      bus.dev_data_i[6*32 +: 32] = 32'h000000FF;
    end else if (p_addr == 32'hFFFFFF40) begin
      bus.dev_ack_i[2] = 1'b1;
      bus.dev_data_i[2*32 +: 32] = 32'hCAFE0000;
    end
  endtask

  // device model: respond one cycle after the strobe, slow device three
  initial begin
    bus.dev_data_i = '0;
    bus.dev_ack_i  = '0;
    bus.dev_err_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      bus.dev_data_i = '0;
      bus.dev_ack_i  = '0;
      bus.dev_err_i  = '0;
      if (pend_cnt == 1) devRespond();
      if (pend_cnt > 0) pend_cnt--;
      if (bus.io_rden_o || bus.io_wren_o) begin
        p_addr   = bus.io_addr_o;
        p_data   = bus.io_data_o;
        p_ben    = bus.io_ben_o;
        p_wr     = bus.io_wren_o;
        pend_cnt = (bus.io_addr_o == 32'hFFFFFF40) ? 3 : 1;
      end
    end
  end

  // monitor: compare every host response against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (bus.io_rden_o || bus.io_wren_o) strobe_cnt++;
      if (bus.ack_o || bus.err_o) begin
        checkOutput("ack_err_excl", {31'b0, bus.ack_o & bus.err_o}, 32'h0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got ack=%b err=%b data=%h at cycle %0d, required none",
                   bus.ack_o, bus.err_o, bus.data_o, cyc);
        end else begin
          e = sb_q.pop_front();
          checkOutput("resp_err", {31'b0, bus.err_o}, {31'b0, e.is_err});
          checkOutput("resp_data", bus.data_o, e.data);
          checkOutput("resp_cycle", cyc, e.cyc);
        end
      end else begin
        checkOutput("data_idle", bus.data_o, 32'h0);
      end
    end
  end

  // present one request for one cycle; lat 0 means no response expected
  task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [31:0] data, input logic [3:0] ben,
                               input logic accepted, input logic is_err,
                               input logic [31:0] exp_data, input int lat);
    exp_t e;
    @(posedge clk_i);
    #1;
    bus.addr_i = addr;
    bus.rden_i = rd;
    bus.wren_i = wr;
    bus.data_i = data;
    bus.ben_i  = ben;
    if (accepted) exp_strobes++;
    if (lat > 0) begin
      e.is_err = is_err;
      e.data   = exp_data;
      e.cyc    = cyc + lat;
      sb_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    bus.addr_i = '0;
    bus.rden_i = 1'b0;
    bus.wren_i = 1'b0;
    bus.data_i = '0;
    bus.ben_i  = '0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk_i);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_timeout: got %0d pending responses, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    rst_i      = 1'b1;
    bus.addr_i = '0;
    bus.rden_i = 1'b0;
    bus.wren_i = 1'b0;
    bus.data_i = '0;
    bus.ben_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_data_o", bus.data_o, 32'h0);
    checkOutput("rst_ack_o", {31'b0, bus.ack_o}, 32'h0);
    checkOutput("rst_err_o", {31'b0, bus.err_o}, 32'h0);
    checkOutput("rst_io_addr", bus.io_addr_o, 32'h0);
    checkOutput("rst_io_data", bus.io_data_o, 32'h0);
    checkOutput("rst_io_ben", {28'b0, bus.io_ben_o}, 32'h0);
    checkOutput("rst_io_strb", {30'b0, bus.io_rden_o, bus.io_wren_o}, 32'h0);
    rst_i = 1'b0;

    $display("[TB] SYSINFO word 0 read");
    applyStimulus(32'hFFFFFFE0, 1'b1, 1'b0, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'h05F5E100, 3);
    checkOutput("rd_strobe", {30'b0, bus.io_rden_o, bus.io_wren_o}, 32'h2);
    checkOutput("rd_io_addr", bus.io_addr_o, 32'hFFFFFFE0);
    checkOutput("rd_io_data", bus.io_data_o, 32'h0);
    waitIdle();
    checkOutput("addr_hold", bus.io_addr_o, 32'hFFFFFFE0);

    $display("[TB] write to read-only SYSINFO");
    applyStimulus(32'hFFFFFFE0, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 32'h0, 3);
    checkOutput("wr_strobe", {30'b0, bus.io_rden_o, bus.io_wren_o}, 32'h1);
    checkOutput("wr_io_data", bus.io_data_o, 32'hDEADBEEF);
    checkOutput("wr_io_ben", {28'b0, bus.io_ben_o}, 32'hF);
    waitIdle();

    $display("[TB] silent device timeout");
    applyStimulus(32'hFFFFFF00, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 16);
    waitIdle();

    $display("[TB] outside window");
    applyStimulus(32'h00000100, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 0);
    repeat (20) @(posedge clk_i);
    checkOutput("strobes_outside", strobe_cnt, exp_strobes);

    $display("[TB] scratch register writes and read");
    applyStimulus(32'hFFFFFE00, 1'b0, 1'b1, 32'hA5A51234, 4'hF, 1'b1, 1'b0, 32'h0, 3);
    waitIdle();
    applyStimulus(32'hFFFFFE00, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h3, 1'b1, 1'b0, 32'h0, 3);
    waitIdle();
    applyStimulus(32'hFFFFFE00, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'hA5A5FFFF, 3);
    waitIdle();

    $display("[TB] request while BUSY is ignored");
    applyStimulus(32'hFFFFFFE4, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h00000101, 3);
    applyStimulus(32'hFFFFFE00, 1'b0, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 0);
    waitIdle();
    checkOutput("strobes_busy", strobe_cnt, exp_strobes);
    applyStimulus(32'hFFFFFE00, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'hA5A5FFFF, 3);
    waitIdle();

    $display("[TB] read and write together act as write");
    applyStimulus(32'hFFFFFE00, 1'b1, 1'b1, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0, 3);
    checkOutput("rw_strobe", {30'b0, bus.io_rden_o, bus.io_wren_o}, 32'h1);
    waitIdle();
    applyStimulus(32'hFFFFFE00, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h11223344, 3);
    waitIdle();

    $display("[TB] decode conflict");
    applyStimulus(32'hFFFFFF80, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 3);
    waitIdle();

    $display("[TB] reset mid-operation");
    applyStimulus(32'hFFFFFF40, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_resp", {30'b0, bus.ack_o, bus.err_o}, 32'h0);
    checkOutput("mid_rst_data", bus.data_o, 32'h0);
    checkOutput("mid_rst_io_addr", bus.io_addr_o, 32'h0);
    checkOutput("mid_rst_io_strb", {30'b0, bus.io_rden_o, bus.io_wren_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (8) @(posedge clk_i);
    checkOutput("strobes_reset", strobe_cnt, exp_strobes);
    applyStimulus(32'hFFFFFFE0, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h05F5E100, 3);
    waitIdle();
    checkOutput("strobes_final", strobe_cnt, exp_strobes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cellrv32_io_gateway.md
# cellrv32_io_gateway

Single-outstanding gateway between the CPU data bus and the processor-internal IO device space; SYSINFO and the other IO peripherals sit directly downstream of it. It decodes the IO address window, registers each request into one-cycle device strobes, merges the wired-OR device responses, and answers the host with a registered ack, error or data word. A bus-timeout error is raised when no device responds within the timeout limit.

## Interface
- `TIMEOUT`, 15: IO bus timeout limit, counted in BUSY cycles; must be at least 2.
- `NUM_DEV`, 8: number of attached IO devices.
- `IO_BASE`, 32'hFFFFFE00: IO window base address; aligned to IO_SIZE.
- `IO_SIZE`, 512: IO window size in bytes; power of 2.
- `clk_i`  in  1  single system clock; everything is on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `addr_i`  in  32  host address.
- `rden_i` / `wren_i`  in  1 each  host read / write request pulse.
- `data_i`  in  32  host write data.
- `ben_i`  in  4  host byte enables.
- `data_o`  out  32  host read data.
- `ack_o` / `err_o`  out  1 each  host completion / error pulse.
- `io_addr_o`  out  32  device address.
- `io_rden_o` / `io_wren_o`  out  1 each  device strobes.
- `io_data_o`  out  32  device write data.
- `io_ben_o`  out  4  device byte enables.
- `dev_data_i`  in  NUM_DEV*32  device read data; a device drives zero when it is not responding.
- `dev_ack_i` / `dev_err_i`  in  NUM_DEV each  device acks / errors.

## Operation
- **FSM states:** IDLE, BUSY.
- **Accept (IDLE only):** the gateway accepts when (rden_i | wren_i) is high and addr_i[31:log2(IO_SIZE)] equals the matching bits of IO_BASE. On accept it latches addr, data and ben, asserts the matching strobe for exactly one cycle, and goes to BUSY.
  - io_data_o carries data_i on a write and 0 on a read.
  - If rden_i and wren_i are both high, the request is treated as a write.
- **Ignored inputs:** requests outside the window, requests arriving while BUSY, and any device response seen while IDLE.
- **Response merge:** data = OR of all dev_data_i slices; ack = |dev_ack_i; err = |dev_err_i.
- **BUSY, one check per cycle, in priority order:**
  - err, or more than one ack bit high: err_o pulses, data_o = 0, go to IDLE.
  - exactly one ack: ack_o pulses, data_o = merged data on a read and 0 on a write, go to IDLE.
  - no response for TIMEOUT BUSY cycles: err_o pulses (timeout), go to IDLE.
- **Counter:** width $clog2(TIMEOUT+1), saturating, cleared on entering BUSY.
- **Output hold:** io_addr_o, io_data_o and io_ben_o hold their latched values until the next accept.

## Timing
- **Reset:** every output is 0 (data_o, ack_o, err_o, all io_* outputs), the FSM is in IDLE and the counter is 0.
- **Reset mid-operation:** the FSM returns to IDLE at once; no ack or err is produced for the aborted access.
- **Cycle numbering:**
  - Cycle 0: request sampled.
  - Cycle 1: strobe on io_*, first BUSY cycle.
  - Cycle k: device response seen in BUSY cycle k (k ≥ 1).
  - Cycle k+1: ack_o or err_o.
- **Latency:** a SYSINFO-style device (acks one cycle after its strobe, k = 2) gives ack_o at cycle 3.
- **Timeout:** err_o is at cycle TIMEOUT+1 after the request.
- **Output pulses:** ack_o and err_o are one-cycle pulses and never high together. data_o is valid only while ack_o is high and is 0 in every other cycle.
- **Back-to-back:** the earliest next accept is the cycle in which ack_o/err_o is high, so at most one request is in flight.

## Structure
- **Shared cellrv32_package:** reuse the existing IO base and size constants (io_base_c, io_size_c) for the IO_BASE / IO_SIZE defaults and index_size_f for the window bit. Add `io_gw_state_t` (IDLE, BUSY) and `io_gw_timeout_c`.
- **No sub-module:** the response merge (OR-reduction plus a more-than-one-ack check) is an inline function, one FSM, one counter.

## Test plan
- **Read SYSINFO word 0:** with CLOCK_FREQUENCY = 100000000, read 32'hFFFFFFE0 → io_rden_o at cycle 1; ack_o at cycle 3 with data_o = 32'h05F5E100 and err_o = 0.
- **Read-only device:** write 32'hDEADBEEF with ben 4'hF to a device that answers with err → err_o at cycle 3, ack_o = 0, io_data_o = 32'hDEADBEEF during BUSY.
- **Silent device:** read an address no device decodes → err_o exactly at cycle 16 (TIMEOUT = 15), no ack_o.
- **Outside window / while BUSY:** read 32'h00000100 → no strobe, no ack/err. A second request issued while BUSY is ignored; only one ack is seen.
- **Decode conflict:** two dev_ack_i bits high in the same cycle → err_o, data_o = 0.
- **Reset mid-operation:** assert rst_i in BUSY cycle 2 → all outputs 0 immediately; a later response is ignored; the next read completes normally.
